// File: rtl/cmd_initiator.sv
// Host-side command initiator: sends {op, data} as one UART 8N1 byte and collects the target's state report.
// Define CMD_INIT_RETRY_EN to resend a setup/query byte once after its first response timeout.
module cmd_initiator #(
    parameter int CLK_HZ      = 50000000,
    parameter int BAUD        = 115200,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_req_vld,
    output logic       out_req_rdy,
    input  logic [1:0] in_req_op,
    input  logic [5:0] in_req_data,
    output logic       out_txd,
    input  logic       in_rsp_vld,
    input  logic [7:0] in_rsp_byte,
    output logic       out_done,
    output logic [5:0] out_rsp_data,
    output logic       out_rsp_err,
    output logic       out_timeout,
    output logic       out_busy
);
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int BAUD_W = $clog2(DIV);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(DIV - 1);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]        OP_ILLEGAL = 2'b00;
    localparam logic [1:0]        OP_RESET   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        WAIT_RSP,
        FINISH
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        op_q;
    logic [7:0]        byte_q;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx, bit_d;
    logic [TO_W-1:0]   to_cnt;
    logic              txd_q, txd_d;
    logic [5:0]        rsp_data_q;
    logic              err_q, to_q;
    logic              accept, in_tx, baud_tick, rsp_hit, to_hit;
`ifdef CMD_INIT_RETRY_EN
    logic              retry_q, retry_go;
`endif

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        rsp_hit   = 1'b0;
        to_hit    = 1'b0;
        bit_d     = 3'd0;
        txd_d     = 1'b1;
`ifdef CMD_INIT_RETRY_EN
        retry_go  = 1'b0;
`endif
        in_tx     = (state_q == TX_START) || (state_q == TX_DATA) || (state_q == TX_STOP);
        baud_tick = in_tx && (baud_cnt == BAUD_LAST);

        case (state_q)
            IDLE: begin
                if (in_req_vld) begin
                    accept  = 1'b1;
                    state_d = (in_req_op == OP_ILLEGAL) ? FINISH : TX_START;
                end
            end
            TX_START: if (baud_tick) state_d = TX_DATA;
            TX_DATA:  if (baud_tick && (bit_idx == 3'd7)) state_d = TX_STOP;
            TX_STOP:  if (baud_tick) state_d = (op_q == OP_RESET) ? FINISH : WAIT_RSP;
            WAIT_RSP: begin
                // A response arriving on the terminal count beats the timeout.
                if (in_rsp_vld) begin
                    rsp_hit = 1'b1;
                    state_d = FINISH;
                end else if (to_cnt == TO_LAST) begin
`ifdef CMD_INIT_RETRY_EN
                    if (!retry_q) begin
                        retry_go = 1'b1;
                        state_d  = TX_START;
                    end else begin
                        to_hit  = 1'b1;
                        state_d = FINISH;
                    end
`else
                    to_hit  = 1'b1;
                    state_d = FINISH;
`endif
                end
            end
            FINISH:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (state_q == TX_DATA) begin
            bit_d = baud_tick ? bit_idx + 3'd1 : bit_idx;
        end

        // The line is registered from the next state so each bit lines up with its state.
        case (state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = byte_q[bit_d];
            default:  txd_d = 1'b1;
        endcase

        out_req_rdy  = (state_q == IDLE);
        out_busy     = (state_q != IDLE);
        out_done     = (state_q == FINISH);
        out_txd      = txd_q;
        out_rsp_data = rsp_data_q;
        out_rsp_err  = err_q;
        out_timeout  = to_q;
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            op_q       <= 2'b00;
            byte_q     <= 8'h00;
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
            to_cnt     <= '0;
            txd_q      <= 1'b1;
            rsp_data_q <= 6'd0;
            err_q      <= 1'b0;
            to_q       <= 1'b0;
`ifdef CMD_INIT_RETRY_EN
            retry_q    <= 1'b0;
`endif
        end else begin
            txd_q    <= txd_d;
            bit_idx  <= bit_d;
            baud_cnt <= (in_tx && !baud_tick) ? baud_cnt + 1'b1 : '0;
            to_cnt   <= ((state_q == WAIT_RSP) && !in_rsp_vld) ? to_cnt + 1'b1 : '0;

            if (accept) begin
                op_q   <= in_req_op;
                byte_q <= {in_req_op, in_req_data};
                err_q  <= (in_req_op == OP_ILLEGAL);
                to_q   <= 1'b0;
            end
            if (rsp_hit) begin
                rsp_data_q <= in_rsp_byte[5:0];
                err_q      <= |in_rsp_byte[7:6];
            end
            if (to_hit) begin
                to_q <= 1'b1;
            end
`ifdef CMD_INIT_RETRY_EN
            if (accept) begin
                retry_q <= 1'b0;
            end else if (retry_go) begin
                retry_q <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_cmd_initiator.sv
// Bench for cmd_initiator: request driver feeds a transaction-level model; monitors check the line and completions.
`timescale 1ns/1ps
module tb_cmd_initiator;
    localparam int CLK_HZ      = 1000;
    localparam int BAUD        = 100;
    localparam int TIMEOUT_CYC = 50;
    localparam int DIV         = CLK_HZ / BAUD;
    localparam int FRAME       = 10 * DIV;
`ifdef CMD_INIT_RETRY_EN
    localparam int ATTEMPTS = 2;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_vld = 1'b0;
    logic       req_rdy;
    logic [1:0] req_op = 2'b00;
    logic [5:0] req_data = 6'd0;
    logic       txd;
    logic       rsp_vld = 1'b0;
    logic [7:0] rsp_byte = 8'h00;
    logic       done;
    logic [5:0] rsp_data;
    logic       rsp_err;
    logic       timeout;
    logic       busy;

    cmd_initiator #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .in_clk(clk), .in_rst(rst),
        .in_req_vld(req_vld), .out_req_rdy(req_rdy), .in_req_op(req_op), .in_req_data(req_data),
        .out_txd(txd), .in_rsp_vld(rsp_vld), .in_rsp_byte(rsp_byte),
        .out_done(done), .out_rsp_data(rsp_data), .out_rsp_err(rsp_err),
        .out_timeout(timeout), .out_busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int fin; logic [5:0] data; logic err; logic to; } done_t;
    typedef struct { int start; logic [7:0] b; } frame_t;

    done_t  done_q[$];
    frame_t frame_q[$];
    int     tests = 0;
    int     fails = 0;

    // Transaction-level model state: what the status outputs should hold between commands.
    logic [5:0] m_data = 6'd0;
    logic       m_err = 1'b0;
    logic       m_to = 1'b0;
    int         idle_at = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor: every out_done must match the oldest outstanding expectation, on its cycle.
    done_t mon_d;
    logic  mon_due;
    always @(negedge clk) begin
        if (rst) begin
            mon_due = 1'b0;
            if (done_q.size() > 0) mon_due = (done_q[0].fin <= cyc);
            if (done || mon_due) begin
                check("done_timing", 32'(done), 32'(mon_due));
                if (done_q.size() > 0) begin
                    mon_d = done_q.pop_front();
                    if (done) begin
                        check("rsp_data", 32'(rsp_data), 32'(mon_d.data));
                        check("rsp_err", 32'(rsp_err), 32'(mon_d.err));
                        check("timeout", 32'(timeout), 32'(mon_d.to));
                    end
                end
            end
        end
    end

    // Line monitor: expected level comes from the frame schedule; mismatches are reported per frame.
    logic tx_exp;
    int   tx_slot;
    int   line_bad = 0;
    int   first_bad = -1;
    always @(negedge clk) begin
        tx_exp = 1'b1;
        if (rst && frame_q.size() > 0 && cyc >= frame_q[0].start) begin
            tx_slot = (cyc - frame_q[0].start) / DIV;
            if (tx_slot == 0) tx_exp = 1'b0;
            else if (tx_slot <= 8) tx_exp = frame_q[0].b[tx_slot-1];
        end
        if (txd !== tx_exp) begin
            line_bad++;
            if (first_bad < 0) first_bad = cyc;
        end
        if (rst && frame_q.size() > 0 && cyc == frame_q[0].start + FRAME - 1) begin
            tests++;
            if (line_bad != 0) begin
                fails++;
                $display("FAIL txd_frame byte %02h: %0d wrong line cycles (first at %0d), required 0",
                         frame_q[0].b, line_bad, first_bad);
            end
            line_bad  = 0;
            first_bad = -1;
            void'(frame_q.pop_front());
        end
    end

    // rsp_off < 0 means the target never answers.
    task automatic run_txn(input logic [1:0] op, input logic [5:0] data, input int rsp_off,
                           input logic [7:0] rb, input bit noise, input int gap);
        int t0, a, f, w, k;
        logic [7:0] bv;
        t0 = cyc;
        while (req_rdy !== 1'b1 && cyc - t0 < 3000) step();
        check("ready_wait", 32'(req_rdy), 32'd1);
        if (req_rdy !== 1'b1) return;
        if (idle_at >= 0) check("ready_cycle", 32'(cyc), 32'(idle_at));
        check("held_err", 32'(rsp_err), 32'(m_err));
        check("held_timeout", 32'(timeout), 32'(m_to));
        check("held_data", 32'(rsp_data), 32'(m_data));
        repeat (gap) step();

        req_vld  = 1'b1;
        req_op   = op;
        req_data = data;
        a  = cyc + 1;
        bv = {op, data};
        m_to = 1'b0;
        w = 0;
        if (op == 2'b00) begin
            m_err = 1'b1;
            f = a;
        end else begin
            m_err = 1'b0;
            frame_q.push_back('{a, bv});
            if (op == 2'b11) begin
                f = a + FRAME;
            end else if (rsp_off >= 0) begin
                w = a + FRAME + rsp_off;
                m_data = rb[5:0];
                m_err  = |rb[7:6];
                f = w + 1;
            end else begin
                f = a + FRAME + TIMEOUT_CYC;
                for (int i = 1; i < ATTEMPTS; i++) begin
                    frame_q.push_back('{f, bv});
                    f = f + FRAME + TIMEOUT_CYC;
                end
                m_to = 1'b1;
            end
        end
        done_q.push_back('{f, m_data, m_err, m_to});
        idle_at = f + 1;

        step();
        req_vld  = 1'b0;
        req_op   = 2'($urandom);
        req_data = 6'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        check("err_on_accept", 32'(rsp_err), 32'(op == 2'b00));
        check("timeout_on_accept", 32'(timeout), 32'd0);

        if (noise && op != 2'b00) begin
            k = $urandom_range(FRAME - 2, 0);
            while (cyc < a + k) step();
            rsp_vld  = 1'b1;
            rsp_byte = 8'($urandom);
            req_vld  = 1'b1;
            step();
            rsp_vld = 1'b0;
            req_vld = 1'b0;
        end
        if (op != 2'b00 && op != 2'b11 && rsp_off >= 0) begin
            while (cyc < w) step();
            rsp_vld  = 1'b1;
            rsp_byte = rb;
            step();
            rsp_vld  = 1'b0;
        end
    endtask

    logic [1:0] r_op;
    logic [5:0] r_data;
    logic [7:0] r_rb;
    int         r_off, r_sel, r_gap, t_end, a_rst;
    bit         r_noise;

    initial begin
        repeat (3) step();
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_data", 32'(rsp_data), 32'd0);
        check("reset_err", 32'(rsp_err), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rdy", 32'(req_rdy), 32'd1);
        rst = 1'b1;
        step();

        run_txn(2'b10, 6'h15, 7, 8'h2A, 1'b0, 0);
        run_txn(2'b11, 6'h00, -1, 8'h00, 1'b0, 0);
        run_txn(2'b01, 6'h00, -1, 8'h00, 1'b0, 0);
        run_txn(2'b00, 6'h2A, -1, 8'h00, 1'b0, 0);
        run_txn(2'b01, 6'h09, 20, 8'h85, 1'b0, 1);
        run_txn(2'b10, 6'h33, TIMEOUT_CYC - 1, 8'h11, 1'b0, 0);

        for (int n = 0; n < 24; n++) begin
            r_op   = 2'($urandom);
            r_data = 6'($urandom);
            r_rb   = 8'($urandom);
            if ($urandom_range(1, 0) == 1) r_rb[7:6] = 2'b00;
            r_sel = $urandom_range(4, 0);
            if (r_sel == 0) r_off = -1;
            else if (r_sel == 1) r_off = TIMEOUT_CYC - 1;
            else r_off = $urandom_range(TIMEOUT_CYC - 2, 0);
            r_noise = bit'($urandom_range(1, 0));
            r_gap   = $urandom_range(3, 0);
            run_txn(r_op, r_data, r_off, r_rb, r_noise, r_gap);
        end

        // Asynchronous reset in the middle of data bit 3 (a zero bit of 0x95).
        t_end = cyc;
        while (req_rdy !== 1'b1 && cyc - t_end < 3000) step();
        check("ready_wait_rst", 32'(req_rdy), 32'd1);
        req_vld  = 1'b1;
        req_op   = 2'b10;
        req_data = 6'h15;
        a_rst = cyc + 1;
        frame_q.push_back('{a_rst, 8'h95});
        step();
        req_vld = 1'b0;
        while (cyc < a_rst + 4 * DIV + 3) step();
        check("line_before_rst", 32'(txd), 32'd0);
        #2;
        rst = 1'b0;
        done_q.delete();
        frame_q.delete();
        #1;
        check("rst_txd_async", 32'(txd), 32'd1);
        check("rst_busy_async", 32'(busy), 32'd0);
        check("rst_rdy_async", 32'(req_rdy), 32'd1);
        check("rst_data_async", 32'(rsp_data), 32'd0);
        m_data  = 6'd0;
        m_err   = 1'b0;
        m_to    = 1'b0;
        idle_at = -1;
        step();
        step();
        rst = 1'b1;
        step();
        run_txn(2'b10, 6'h0A, 12, 8'h3C, 1'b0, 0);
        run_txn(2'b01, 6'h21, 3, 8'h07, 1'b1, 0);

        t_end = cyc;
        while (done_q.size() > 0 && cyc - t_end < 3000) step();
        check("drain", 32'(done_q.size()), 32'd0);
        step();
        step();
        check("line_idle_end", 32'(line_bad), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
